// File: rtl/sim_fifo_pkg.sv
// sim_fifo_pkg: shared constants and helpers for the sim_fifo_flex FIFO.
// Holds the read-mode selectors and the occupancy counter width helper.
package sim_fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // Occupancy counter needs one bit more than the pointers to represent "full"
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sim_fifo_ram.sv
// sim_fifo_ram: FIFO storage array.
// One synchronous write port and one asynchronous read port; contents are
// never reset, so stale words survive a FIFO reset by design.
module sim_fifo_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Write the incoming word on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads are combinational so the controller sees the head word immediately
  assign rdata = mem[raddr];

endmodule

// File: rtl/sim_fifo_flex.sv
// sim_fifo_flex: synchronous FIFO with selectable registered-read or
// first-word-fall-through output, occupancy count and threshold flags.
// Optional sticky overflow/underflow flags are built only when the macro
// SIM_FIFO_ERR_FLAGS_EN is defined; otherwise those ports are tied low.
module sim_fifo_flex
  import sim_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 4,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW        = count_width(ADDR_WIDTH);

  localparam logic [CW-1:0] FULL_LVL   = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  sim_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Status flags derive only from the registered occupancy
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == FULL_LVL);
    almost_empty = (count_q <= AEMPTY_LVL);
    almost_full  = (count_q >= AFULL_LVL);
    fifo_count   = count_q;
  end

  // Decide which requests take effect and compute next pointers and count;
  // a pop frees a slot in the same cycle, so push while full is allowed with pop
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is exposed directly; forced to zero while nothing is stored
    assign data_out = empty ? '0 : ram_rdata;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    // Capture the head word on each accepted pop and hold it otherwise
    always_comb begin
      data_out_d = data_out_q;
      if (pop_ok) begin
        data_out_d = ram_rdata;
      end
    end

    // Output register for registered-read mode
    always_ff @(posedge clk) begin
      if (reset) begin
        data_out_q <= '0;
      end else begin
        data_out_q <= data_out_d;
      end
    end

    assign data_out = data_out_q;
  end

`ifdef SIM_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A dropped push or an ignored pop latches its flag until reset;
  // a pop paired with a push on an empty FIFO is not an underflow
  always_comb begin
    overflow_d  = overflow_q  || (push && full && !pop);
    underflow_d = underflow_q || (pop && empty && !push);
  end

  // Sticky error flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sim_fifo_flex.sv
// tb_sim_fifo_flex: self-checking bench for sim_fifo_flex.
// Drives one registered-read and one FWFT instance with identical stimulus
// and compares both against a queue-based reference model, plus fixed vectors.
module tb_sim_fifo_flex;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

`ifdef SIM_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, push, pop;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout0, dout1;
  logic          empty0, full0, ae0, af0, ovf0, unf0;
  logic          empty1, full1, ae1, af1, ovf1, unf1;
  logic [AW:0]   count0, count1;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_reg_out;
  bit            m_ovf, m_unf;

  always #5 clk = ~clk;

  sim_fifo_flex #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
    .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut_reg (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout0), .empty(empty0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .fifo_count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sim_fifo_flex #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
    .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut_fwft (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout1), .empty(empty1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .fifo_count(count1), .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    logic          rst;
    logic          psh;
    logic          pp;
    logic [DW-1:0] din;
    int            exp_count;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_af;
    logic [DW-1:0] exp_dout;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance the reference model by one clock edge, from the spec's rules
  task automatic modelStep(input logic r, input logic p, input logic pp, input logic [DW-1:0] d);
    int  n;
    bit  was_full, was_empty;
    if (r) begin
      mq.delete();
      m_reg_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    n = mq.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (pp && !was_empty) m_reg_out = mq.pop_front();
    if (p && (!was_full || pp)) mq.push_back(d);
    if (ERR_EN && p && was_full && !pp) m_ovf = 1'b1;
    if (ERR_EN && pp && was_empty && !p) m_unf = 1'b1;
  endtask

  // Drive one cycle of inputs, clock it, and update the model
  task automatic applyStimulus(input logic r, input logic p, input logic pp, input logic [DW-1:0] d);
    @(negedge clk);
    reset = r;
    push = p;
    pop = pp;
    data_in = d;
    @(posedge clk);
    #1;
    modelStep(r, p, pp, d);
  endtask

  // Compare both DUT instances against the model
  task automatic checkOutput(input string tag);
    int n;
    n = mq.size();
    checkValue({tag, " count_reg"}, 32'(count0), 32'(n));
    checkValue({tag, " count_fwft"}, 32'(count1), 32'(n));
    checkValue({tag, " empty"}, {30'b0, empty1, empty0}, {30'b0, n == 0, n == 0});
    checkValue({tag, " full"}, {30'b0, full1, full0}, {30'b0, n == DEPTH, n == DEPTH});
    checkValue({tag, " almost_empty"}, {30'b0, ae1, ae0}, {30'b0, n <= 1, n <= 1});
    checkValue({tag, " almost_full"}, {30'b0, af1, af0}, {30'b0, n >= 3, n >= 3});
    checkValue({tag, " overflow"}, {30'b0, ovf1, ovf0}, {30'b0, m_ovf, m_ovf});
    checkValue({tag, " underflow"}, {30'b0, unf1, unf0}, {30'b0, m_unf, m_unf});
    checkValue({tag, " dout_reg"}, 32'(dout0), 32'(m_reg_out));
    if (n != 0) checkValue({tag, " dout_fwft"}, 32'(dout1), 32'(mq[0]));
  endtask

  vec_t vecs[13];

  initial begin
    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    mq.delete();
    m_reg_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;

    // fill, overflow attempt, push+pop while full, drain, underflow, reset
    vecs[0]  = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 1, 0, 8'h11, 1, 0, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{0, 1, 0, 8'h22, 2, 0, 0, 0, 8'h00, 0, 0};
    vecs[3]  = '{0, 1, 0, 8'h33, 3, 0, 0, 1, 8'h00, 0, 0};
    vecs[4]  = '{0, 1, 0, 8'h44, 4, 1, 0, 1, 8'h00, 0, 0};
    vecs[5]  = '{0, 1, 0, 8'h66, 4, 1, 0, 1, 8'h00, 1, 0};
    vecs[6]  = '{0, 1, 1, 8'h55, 4, 1, 0, 1, 8'h11, 1, 0};
    vecs[7]  = '{0, 0, 1, 8'h00, 3, 0, 0, 1, 8'h22, 1, 0};
    vecs[8]  = '{0, 0, 1, 8'h00, 2, 0, 0, 0, 8'h33, 1, 0};
    vecs[9]  = '{0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h44, 1, 0};
    vecs[10] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 8'h55, 1, 0};
    vecs[11] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 8'h55, 1, 1};
    vecs[12] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0};

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].din);
      checkValue({tag, " tbl_count"}, 32'(count0), 32'(vecs[i].exp_count));
      checkValue({tag, " tbl_full"}, 32'(full0), 32'(vecs[i].exp_full));
      checkValue({tag, " tbl_empty"}, 32'(empty0), 32'(vecs[i].exp_empty));
      checkValue({tag, " tbl_afull"}, 32'(af0), 32'(vecs[i].exp_af));
      checkValue({tag, " tbl_dout"}, 32'(dout0), 32'(vecs[i].exp_dout));
      checkValue({tag, " tbl_ovf"}, 32'(ovf0), 32'(vecs[i].exp_ovf & ERR_EN));
      checkValue({tag, " tbl_unf"}, 32'(unf0), 32'(vecs[i].exp_unf & ERR_EN));
      checkOutput(tag);
    end

    // FWFT: single word becomes visible without a pop, then popping empties
    applyStimulus(0, 1, 0, 8'hA5);
    checkValue("fwft_a5 dout", 32'(dout1), 32'h0000_00A5);
    checkValue("fwft_a5 empty", 32'(empty1), 32'h0);
    checkOutput("fwft_a5");
    applyStimulus(0, 0, 1, 8'h00);
    checkValue("fwft_a5_pop empty", 32'(empty1), 32'h1);
    checkValue("fwft_a5_pop dout_reg", 32'(dout0), 32'h0000_00A5);
    checkOutput("fwft_a5_pop");

    // push and pop together on an empty FIFO: only the push lands
    applyStimulus(0, 1, 1, 8'h7E);
    checkValue("pp_empty count", 32'(count0), 32'h1);
    checkValue("pp_empty underflow", 32'(unf0), 32'h0);
    checkValue("pp_empty dout_fwft", 32'(dout1), 32'h0000_007E);
    checkOutput("pp_empty");
    applyStimulus(0, 0, 1, 8'h00);
    checkValue("pp_empty_pop dout_reg", 32'(dout0), 32'h0000_007E);
    checkOutput("pp_empty_pop");

    // wrap pointers twice at count 2, then reset mid-stream
    applyStimulus(0, 1, 0, 8'h01);
    applyStimulus(0, 1, 0, 8'h02);
    checkOutput("wrap_fill");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, 8'(8'h10 + i));
      checkOutput($sformatf("wrap%0d", i));
    end
    checkValue("wrap count", 32'(count0), 32'h2);
    applyStimulus(1, 1, 1, 8'hEE);
    checkValue("wrap_reset count", 32'(count0), 32'h0);
    checkValue("wrap_reset empty", 32'(empty0), 32'h1);
    checkValue("wrap_reset dout_reg", 32'(dout0), 32'h0);
    checkValue("wrap_reset dout_fwft", 32'(dout1), 32'h0);
    checkOutput("wrap_reset");

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic r, p, pp;
      r  = ($urandom_range(0, 63) == 0);
      p  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35));
      pp = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65));
      applyStimulus(r, p, pp, 8'($urandom));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sim_fifo_flex.md
SIM_FIFO_FLEX -- requirements
Module: sim_fifo_flex

Interface
REQ-001 Parameter DATA_WIDTH, default 64, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, pointer width; depth RAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AFULL_THRESH, default RAM_DEPTH-2, almost-full level; legal range 1..RAM_DEPTH.
REQ-005 Parameter AEMPTY_THRESH, default 1, almost-empty level; legal range 0..RAM_DEPTH-1.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 push  input  1  write request.
REQ-009 pop  input  1  read request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 data_out  output  DATA_WIDTH  read data.
REQ-012 empty, full  output  1 each  occupancy == 0 / == RAM_DEPTH.
REQ-013 almost_empty, almost_full  output  1 each  occupancy <= AEMPTY_THRESH / >= AFULL_THRESH.
REQ-014 fifo_count  output  ADDR_WIDTH+1  current occupancy.
REQ-015 overflow, underflow  output  1 each  sticky error flags (see Configuration).

Function
REQ-016 Accepted push = push && (!full || pop); accepted pop = pop && !empty.
REQ-017 Accepted push writes data_in at wr_pointer; wr_pointer increments modulo RAM_DEPTH.
REQ-018 Accepted pop increments rd_pointer modulo RAM_DEPTH.
REQ-019 fifo_count: +1 push only, -1 pop only, unchanged when both or neither accepted.
REQ-020 Push+pop when full: both accepted, count stays RAM_DEPTH, oldest word read, new word stored.
REQ-021 Push+pop when empty: push accepted, pop ignored, count becomes 1.
REQ-022 Push when full without pop: word dropped, no state change besides overflow flag.
REQ-023 Pop when empty: ignored, data_out unchanged, underflow flag set.
REQ-024 All status flags are pure functions of the registered fifo_count, valid the cycle after each edge.
REQ-025 FWFT=0: on accepted pop at edge N, data_out holds the head word from edge N until the next accepted pop; latency 1 cycle.
REQ-026 FWFT=1: data_out shows mem[rd_pointer] whenever empty=0; accepted pop at edge N exposes the next word after edge N.
REQ-027 FWFT=1: word pushed into empty FIFO at edge N visible on data_out, empty=0, after edge N.
REQ-028 FWFT=1 and empty=1: data_out value is don't-care.

Reset
REQ-029 On reset: fifo_count=0, pointers=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-030 Reset dominates push/pop in the same cycle; reset mid-operation discards all stored words; memory contents not cleared.

Configuration
REQ-031 Macro SIM_FIFO_ERR_FLAGS_EN defined: overflow set by REQ-022, underflow by REQ-023, both sticky until reset.
REQ-032 Macro undefined: overflow and underflow ports remain present and are tied to 0; no error logic built.

Structure
REQ-033 Package sim_fifo_pkg holds the FWFT mode constants (MODE_REG=0, MODE_FWFT=1) and a count-width helper function.
REQ-034 Storage in sub-module sim_fifo_ram: single write port, one asynchronous read port, no reset.
REQ-035 Control (pointers, count, flags, output register) lives in sim_fifo_flex.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1)
REQ-036 FWFT=0: push 0x11,0x22,0x33,0x44 -> full=1, almost_full=1 at count 3; 4 pops -> data_out 0x11..0x44, one cycle after each pop, then empty=1.
REQ-037 Full + push 0x55 + pop -> count stays 4, data_out=0x11, later pops 0x22,0x33,0x44,0x55.
REQ-038 Full + push 0x66 without pop -> count 4, 0x66 never read; overflow=1 if SIM_FIFO_ERR_FLAGS_EN, else 0.
REQ-039 FWFT=1: push 0xA5 to empty -> next cycle empty=0, data_out=0xA5 without pop; pop -> empty=1.
REQ-040 Empty + push 0x7E + pop same cycle -> count=1, underflow stays 0, 0x7E read next.
REQ-041 8 pushes/pops interleaved to wrap pointers twice, reset asserted with count=2 -> next cycle count=0, empty=1, data_out=0.
